// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY datapath types: word width and the datapath word used by the
// lane-merge stage and the stripe output FIFO.
package pcie_phy_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage : pcie_phy_pkg

// File: rtl/stripe_fifo_mem.sv
// DEPTH x WORD_W register array: one synchronous write port and one registered
// read port whose output holds between reads. The array itself is not reset.
module stripe_fifo_mem
  import pcie_phy_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  word_t         wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output word_t         rd_data_o
);

  word_t mem_q [DEPTH];
  word_t rd_data_q;

  // Storage write; contents survive reset on purpose.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register: captures the old entry even when written on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : stripe_fifo_mem

// File: rtl/stripe_out_fifo.sv
// FIFO after the lane-merge stage: never backpressures, drops and flags words
// arriving while full. Threshold flags are built only with STRIPE_FIFO_ALMOST_EN.
module stripe_out_fifo
  import pcie_phy_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_2f,
  input  logic          reset,
  input  word_t         data_in,
  input  logic          valid_in,
  input  logic          pop,
  output word_t         data_out,
  output logic          valid_out,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          valid_out_q;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push_ok_s, pop_ok_s;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign pop_ok_s  = pop & ~empty_q;
  assign push_ok_s = valid_in & (~full_q | pop_ok_s);

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (valid_in & full_q & ~pop_ok_s);
    underflow_d = underflow_q | (pop & empty_q);
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; flags are derived from the post-edge count.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == CW'(DEPTH));
      empty_q     <= (count_d == CW'(0));
      valid_out_q <= pop_ok_s;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef STRIPE_FIFO_ALMOST_EN
  logic almost_full_q, almost_empty_q;

  // Threshold flags, registered alongside count.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (count_d >= CW'(AF_LEVEL));
      almost_empty_q <= (count_d <= CW'(AE_LEVEL));
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`else
  logic unused_levels_s;
  assign unused_levels_s = (AF_LEVEL > AE_LEVEL);
  assign almost_full     = 1'b0;
  assign almost_empty    = 1'b0;
`endif

  stripe_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i     (clk_2f),
    .rst_ni    (reset),
    .wr_en_i   (push_ok_s),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (pop_ok_s),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_out)
  );

  assign valid_out = valid_out_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule : stripe_out_fifo
